r8_mbe_pipe_ctrl: RTL and testbench
===================================

Name: r8_mbe_pipe_ctrl

Overview:
Pipeline sequencer for the radix-8 MBE multiplier datapath: operand register, 3A hard-multiple precompute, PP generation plus resize (9 x 33-bit rows), Dadda tree with final CPA. It owns the per-stage valid bits, generates the register load enables, and implements valid/ready handshakes on both the operand and product sides. It also carries a request tag alongside each operation, supports a synchronous flush, and keeps a saturating back-pressure counter. It contains no arithmetic; the datapath registers load only when this block asserts their enables.

Parameters:
N_STAGES, 4, number of datapath register stages sequenced (stage 0 = operand register, stage N_STAGES-1 = product register); legal range 2..8.
TAG_W, 4, width of the request tag carried with each operation.
CNT_W, 16, width of the stall performance counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair presented
in_ready  out  1  controller accepts operand pair this cycle
in_tag  in  TAG_W  tag of the presented request
out_valid  out  1  product register holds a valid result
out_ready  in  1  consumer accepts the result
out_tag  out  TAG_W  tag of the result in the product register
stage_en  out  N_STAGES  load enable for datapath stage register k
flush  in  1  discard all in-flight operations
busy  out  1  any stage valid
inflight  out  4  number of valid stages (0..N_STAGES)
stall_cnt  out  CNT_W  saturating count of back-pressured cycles
stall_clr  in  1  clear stall_cnt

Behaviour:
- State: v[k] and tag[k] for k = 0..N_STAGES-1.
- Reset values: all v = 0, all tag = 0, stall_cnt = 0. Outputs on reset: in_ready = 1, out_valid = 0, out_tag = 0, stage_en = 0, busy = 0, inflight = 0.
- Advance rules (combinational):
  - adv[N-1] = !v[N-1] | out_ready.
  - adv[k] = !v[k] | (v[k] & adv[k+1]) for k < N-1.
  - Result: full-throughput bubble-collapsing pipeline; a stall propagates back only through contiguous valid stages.
- Accept: in_ready = adv[0] & !flush.
  - stage_en[0] = in_valid & in_ready.
  - stage_en[k] = v[k-1] & adv[k] for k >= 1.
  - On stage_en[k], tag[k] loads from tag[k-1] (stage 0 loads from in_tag) and v[k] is set.
  - A valid stage whose content moves on and receives nothing new clears v.
- Outputs: out_valid = v[N-1] and out_tag = tag[N-1], both registered. A result is consumed when out_valid & out_ready.
- Latency: accept in cycle t gives out_valid in cycle t+N_STAGES with no back-pressure. Throughput is 1 operation/cycle.
- Hold rule: while out_valid & !out_ready, out_tag and the product register (stage_en[N-1] = 0) hold stable.
- Flush (has priority over accept and advance):
  - In the flush cycle: in_ready = 0 and stage_en = 0.
  - Next cycle: all v = 0. Tags are not cleared.
  - out_valid drops the cycle after flush, even if out_ready was high in the flush cycle; that result counts as not consumed.
- busy = |v. inflight = popcount(v), registered alongside v.
- stall_cnt:
  - Increments when out_valid & !out_ready and saturates at all-ones.
  - stall_clr is synchronous and has priority over increment.
  - flush does not affect stall_cnt.
- rst mid-operation: all in-flight operations are dropped with no output; same values as the reset state.
- Simultaneous output consume and input accept with the pipeline full: legal, every stage shifts, and inflight stays N_STAGES.

Test Plan:
- Reset, then a single request tag=0x5 with out_ready=1 -> stage_en walks 0001,0010,0100,1000 over cycles t..t+3; out_valid=1 with out_tag=0x5 at t+4 for exactly 1 cycle; inflight returns to 0.
- Back-to-back tags 0x1..0x8 with out_ready=1 -> in_ready stays 1; out_tag sequence 1..8 on consecutive cycles starting 4 cycles after the first accept.
- out_ready=0 with 6 requests offered -> after 4 accepts in_ready=0, inflight=4, out_tag holds 0x1, stall_cnt counts up each cycle; raising out_ready drains 1..4 in order, then the remaining 2 are accepted.
- Bubble collapse: accept tag 0xA, idle 2 cycles, accept 0xB, out_ready=0 -> 0xB advances until it sits behind 0xA (inflight=2, v=1100); no loss on release.
- Flush with 3 in flight and in_valid=1 -> in_ready=0 in the flush cycle; next cycle out_valid=0, busy=0, inflight=0; the offered request is accepted the following cycle and emerges after 4 cycles.
- Saturation: set CNT_W=4 and hold out_ready=0 for 20 cycles -> stall_cnt stops at 0xF; stall_clr asserted with the stall still present -> 0 the next cycle, then increments again.

Source files
------------

// File: rtl/r8_mbe_pipe_ctrl.sv
// Pipeline sequencer for the radix-8 MBE multiplier datapath.
// Tracks per-stage valid bits and request tags, issues datapath register load
// enables, handles operand/product valid-ready handshakes, a synchronous flush
// and a saturating back-pressure counter. No arithmetic lives here.
module r8_mbe_pipe_ctrl #(
  parameter int unsigned N_STAGES = 4,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic [N_STAGES-1:0] stage_en,
  input  logic                flush,
  output logic                busy,
  output logic [3:0]          inflight,
  output logic [CNT_W-1:0]    stall_cnt,
  input  logic                stall_clr
);

  logic [N_STAGES-1:0] v_q;
  logic [N_STAGES-1:0] v_d;
  logic [N_STAGES-1:0] adv;
  logic [TAG_W-1:0]    tag_q [N_STAGES];
  logic [3:0]          inflight_q;
  logic [3:0]          inflight_d;
  logic [CNT_W-1:0]    stall_q;

  // Advance chain: a stage may take new content if it is empty or its content
  // moves on; a scalar carry keeps the chain free of vector self-dependency.
  always_comb begin
    logic a;
    adv = '0;
    a   = !v_q[N_STAGES-1] | out_ready;
    adv[N_STAGES-1] = a;
    for (int unsigned i = 1; i < N_STAGES; i++) begin
      a = !v_q[N_STAGES-1-i] | a;
      adv[N_STAGES-1-i] = a;
    end
  end

  // Load enables and handshake; flush blocks every load and the accept.
  always_comb begin
    in_ready    = adv[0] & !flush;
    stage_en    = '0;
    stage_en[0] = in_valid & adv[0] & !flush;
    for (int unsigned k = 1; k < N_STAGES; k++) begin
      stage_en[k] = v_q[k-1] & adv[k] & !flush;
    end
  end

  // Next valid state and its population count (registered with v).
  always_comb begin
    v_d        = '0;
    inflight_d = '0;
    if (!flush) begin
      for (int unsigned k = 0; k < N_STAGES; k++) begin
        v_d[k] = stage_en[k] | (v_q[k] & !adv[k]);
      end
    end
    for (int unsigned k = 0; k < N_STAGES; k++) begin
      inflight_d = inflight_d + 4'(v_d[k]);
    end
  end

  // Valid bits, occupancy and tag shift register; tags survive a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q        <= '0;
      inflight_q <= '0;
      for (int unsigned k = 0; k < N_STAGES; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      v_q        <= v_d;
      inflight_q <= inflight_d;
      if (stage_en[0]) begin
        tag_q[0] <= in_tag;
      end
      for (int unsigned k = 1; k < N_STAGES; k++) begin
        if (stage_en[k]) begin
          tag_q[k] <= tag_q[k-1];
        end
      end
    end
  end

  // Saturating back-pressure counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall_clr) begin
      stall_q <= '0;
    end else if (v_q[N_STAGES-1] && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign out_valid = v_q[N_STAGES-1];
  assign out_tag   = tag_q[N_STAGES-1];
  assign busy      = |v_q;
  assign inflight  = inflight_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_r8_mbe_pipe_ctrl.sv
// Self-checking bench for r8_mbe_pipe_ctrl: a queue-of-operations model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_r8_mbe_pipe_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush, stall_clr;
  logic [3:0]  in_tag;

  logic        in_ready, out_valid, busy;
  logic [3:0]  out_tag, stage_en, inflight;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_busy;
  logic [3:0]  s_out_tag, s_stage_en, s_inflight, s_stall_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  r8_mbe_pipe_ctrl #(.N_STAGES(4), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .stage_en(stage_en), .flush(flush), .busy(busy),
    .inflight(inflight), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  r8_mbe_pipe_ctrl #(.N_STAGES(4), .TAG_W(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_tag(in_tag), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_tag(s_out_tag), .stage_en(s_stage_en), .flush(flush), .busy(s_busy),
    .inflight(s_inflight), .stall_cnt(s_stall_cnt), .stall_clr(stall_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: in-flight operations, oldest first, each with its stage position.
  typedef struct {
    logic [3:0] tag;
    int         pos;
  } item_t;

  item_t       mq[$];
  item_t       nq[$];
  logic [3:0]  mtag [N];
  logic [3:0]  ntag [N];
  int unsigned m16 = 0;
  int unsigned m4  = 0;
  bit          chk_en = 1'b0;

  always @(negedge clk) begin : model_cmp
    logic       e_ov, e_ir;
    logic [3:0] e_se;
    int         limit, np;
    if (rst) begin
      mq.delete();
      for (int k = 0; k < N; k++) mtag[k] = '0;
      m16    = 0;
      m4     = 0;
      chk_en = 1'b1;
    end else begin
      e_ov  = (mq.size() > 0) && (mq[0].pos == N-1);
      ntag  = mtag;
      nq.delete();
      e_se  = '0;
      limit = N;
      e_ir  = 1'b0;
      if (!flush) begin
        foreach (mq[i]) begin
          if (!(mq[i].pos == N-1 && out_ready)) begin
            if (mq[i].pos == N-1) np = N-1;
            else np = (mq[i].pos + 1 < limit) ? mq[i].pos + 1 : mq[i].pos;
            if (np != mq[i].pos) begin
              e_se[np] = 1'b1;
              ntag[np] = mq[i].tag;
            end
            limit = np;
            nq.push_back('{mq[i].tag, np});
          end
        end
        e_ir = (limit > 0);
        if (in_valid && e_ir) begin
          e_se[0] = 1'b1;
          ntag[0] = in_tag;
          nq.push_back('{in_tag, 0});
        end
      end
      if (chk_en) begin
        chk("m_in_ready",  32'(in_ready),    32'(e_ir));
        chk("m_stage_en",  32'(stage_en),    32'(e_se));
        chk("m_out_valid", 32'(out_valid),   32'(e_ov));
        chk("m_out_tag",   32'(out_tag),     32'(mtag[N-1]));
        chk("m_busy",      32'(busy),        32'(mq.size() > 0));
        chk("m_inflight",  32'(inflight),    32'(mq.size()));
        chk("m_stall16",   32'(stall_cnt),   32'(m16));
        chk("m_stall4",    32'(s_stall_cnt), 32'(m4));
      end
      if (stall_clr) begin
        m16 = 0;
        m4  = 0;
      end else if (e_ov && !out_ready) begin
        m16 = (m16 == 65535) ? 65535 : m16 + 1;
        m4  = (m4 == 15) ? 15 : m4 + 1;
      end
      mq   = nq;
      mtag = ntag;
    end
  end

  initial begin
    int nxt;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; in_tag = '0; out_ready = 1'b1;
    flush = 1'b0; stall_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_tag",   32'(out_tag),   32'd0);
    chk("rst_stage_en",  32'(stage_en),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_inflight",  32'(inflight),  32'd0);
    chk("rst_stall",     32'(stall_cnt), 32'd0);
    step();

    // Single request walks the stages.
    in_valid = 1'b1; in_tag = 4'h5;
    #1;
    chk("t1_se_walk", 32'(stage_en), 32'h1);
    step();
    in_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      #1;
      chk("t1_se_walk", 32'(stage_en), 32'd1 << j);
      step();
    end
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_tag",   32'(out_tag),   32'h5);
    chk("t1_inflight",  32'(inflight),  32'd1);
    step();
    #1;
    chk("t1_out_drop",  32'(out_valid), 32'd0);
    chk("t1_inflight0", 32'(inflight),  32'd0);
    step();

    // Back-to-back stream at full throughput.
    for (int j = 0; j < 12; j++) begin
      in_valid = (j < 8);
      in_tag   = 4'(j + 1);
      #1;
      if (j < 8) chk("t2_in_ready", 32'(in_ready), 32'd1);
      if (j >= 4) begin
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_out_tag",   32'(out_tag),   32'(j - 3));
      end
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Back-pressure: fill, hold, then drain with concurrent accepts.
    nxt = 1;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 8);
      in_valid  = (nxt <= 6);
      in_tag    = 4'(nxt);
      #1;
      if (c == 4) chk("t3_accepts", 32'(nxt), 32'd5);
      if (c >= 4 && c < 8) begin
        chk("t3_in_ready", 32'(in_ready),  32'd0);
        chk("t3_inflight", 32'(inflight),  32'd4);
        chk("t3_hold_tag", 32'(out_tag),   32'h1);
        chk("t3_stall",    32'(stall_cnt), 32'(c - 4));
      end
      if (c == 8) chk("t3_stall_end", 32'(stall_cnt), 32'd4);
      if (c == 9) chk("t3_full_shift", 32'(inflight), 32'd4);
      if (c >= 8) begin
        chk("t3_drain_valid", 32'(out_valid), 32'd1);
        chk("t3_drain_tag",   32'(out_tag),   32'(c - 7));
      end
      acc = in_valid && in_ready;
      step();
      if (acc) nxt++;
    end
    chk("t3_all_accepted", 32'(nxt), 32'd7);
    in_valid = 1'b0;
    repeat (2) step();

    // Bubble collapse behind a stalled head.
    for (int c = 0; c < 10; c++) begin
      out_ready = (c >= 7);
      in_valid  = (c == 0 || c == 3);
      in_tag    = (c == 0) ? 4'hA : 4'hB;
      #1;
      if (c == 5) chk("t4_b_moves", 32'(stage_en), 32'h4);
      if (c == 6) begin
        chk("t4_inflight", 32'(inflight), 32'd2);
        chk("t4_no_move",  32'(stage_en), 32'h0);
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        chk("t4_head_tag", 32'(out_tag),  32'hA);
      end
      if (c == 7) chk("t4_out_a", 32'(out_tag), 32'hA);
      if (c == 8) begin
        chk("t4_valid_b", 32'(out_valid), 32'd1);
        chk("t4_out_b",   32'(out_tag),   32'hB);
      end
      if (c == 9) chk("t4_empty", 32'(out_valid), 32'd0);
      step();
    end
    in_valid = 1'b0;

    // Flush with three in flight and a pending request.
    for (int c = 0; c < 9; c++) begin
      in_valid = (c <= 4);
      in_tag   = (c < 3) ? 4'(c + 1) : 4'hC;
      flush    = (c == 3);
      #1;
      if (c == 3) begin
        chk("t5_fl_in_ready", 32'(in_ready), 32'd0);
        chk("t5_fl_stage_en", 32'(stage_en), 32'd0);
        chk("t5_fl_inflight", 32'(inflight), 32'd3);
      end
      if (c == 4) begin
        chk("t5_post_valid",    32'(out_valid), 32'd0);
        chk("t5_post_busy",     32'(busy),      32'd0);
        chk("t5_post_inflight", 32'(inflight),  32'd0);
        chk("t5_post_accept",   32'(stage_en),  32'h1);
      end
      if (c == 8) begin
        chk("t5_c_valid", 32'(out_valid), 32'd1);
        chk("t5_c_tag",   32'(out_tag),   32'hC);
      end
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    step();

    // Flush while a result is being consumed: it is dropped, tag retained.
    for (int c = 0; c < 6; c++) begin
      in_valid = (c <= 3);
      in_tag   = 4'(c + 1);
      flush    = (c == 4);
      #1;
      if (c == 4) chk("t5b_valid_pre", 32'(out_valid), 32'd1);
      if (c == 5) begin
        chk("t5b_valid_drop", 32'(out_valid), 32'd0);
        chk("t5b_tag_kept",   32'(out_tag),   32'h1);
        chk("t5b_inflight",   32'(inflight),  32'd0);
      end
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b0;

    // Stall counter saturation and clear under stall.
    out_ready = 1'b0;
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 4'h7;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #1;
    chk("t6_out_valid", 32'(out_valid),   32'd1);
    chk("t6_start16",   32'(stall_cnt),   32'd0);
    chk("t6_start4",    32'(s_stall_cnt), 32'd0);
    repeat (20) step();
    chk("t6_cnt16",     32'(stall_cnt),   32'd20);
    chk("t6_sat4",      32'(s_stall_cnt), 32'hF);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    #1;
    chk("t6_clr16", 32'(stall_cnt),   32'd0);
    chk("t6_clr4",  32'(s_stall_cnt), 32'd0);
    step();
    chk("t6_inc16", 32'(stall_cnt),   32'd1);
    chk("t6_inc4",  32'(s_stall_cnt), 32'd1);
    out_ready = 1'b1;
    repeat (2) step();

    // Reset in the middle of operation drops everything.
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 2);
      in_tag   = (c == 0) ? 4'h9 : 4'hA;
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("t7_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t7_out_valid", 32'(out_valid), 32'd0);
    chk("t7_out_tag",   32'(out_tag),   32'd0);
    chk("t7_inflight",  32'(inflight),  32'd0);
    chk("t7_busy",      32'(busy),      32'd0);
    chk("t7_stall",     32'(stall_cnt), 32'd0);
    chk("t7_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
